// File: rtl/crc_serial_check.sv
// Serial CRC checker: receives a payload followed by its CRC one bit at a time
// and reports whether the whole codeword leaves a zero remainder.
module crc_serial_check #(
    parameter int                DATA_W = 10,
    parameter int                CRC_W  = 9,
    parameter logic [CRC_W-1:0]  POLY   = 9'h103
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              busy,
    output logic              frame_done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic [DATA_W-1:0] data_out,
    output logic [7:0]        err_count
);

    localparam int FRAME_W = DATA_W + CRC_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CRC_W-1:0]   lfsr;
    logic [DATA_W-1:0]  payload;

    logic               fb;
    logic               start;
    logic               last_bit;
    logic [CRC_W-1:0]   lfsr_next;
    logic [CRC_W-1:0]   lfsr_first;

    always_comb begin
        fb         = lfsr[CRC_W-1] ^ in_bit;
        lfsr_next  = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        // A new frame clocks its first bit into a cleared register.
        lfsr_first = in_bit ? POLY : '0;
        start      = in_valid && in_sof;
        last_bit   = (cnt == CNT_W'(FRAME_W - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lfsr       <= '0;
            payload    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            data_out   <= '0;
            err_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            // An in_sof always (re)starts a frame, even mid-frame in RECV.
            if (start) begin
                state   <= RECV;
                busy    <= 1'b1;
                cnt     <= CNT_W'(1);
                lfsr    <= lfsr_first;
                payload <= {{(DATA_W-1){1'b0}}, in_bit};
            end else if (state == RECV && in_valid) begin
                cnt  <= cnt + 1'b1;
                lfsr <= lfsr_next;
                if (cnt < CNT_W'(DATA_W))
                    payload <= {payload[DATA_W-2:0], in_bit};
                if (last_bit) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cnt        <= '0;
                    frame_done <= 1'b1;
                    data_out   <= payload;
                    crc_ok     <= (lfsr_next == '0);
                    crc_err    <= (lfsr_next != '0);
                    if (lfsr_next != '0 && err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_serial_check.sv
// Self-checking bench for crc_serial_check: directed and random frames checked
// against a polynomial long-division reference.
module tb_crc_serial_check;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_bit, in_sof;
    logic       busy, frame_done, crc_ok, crc_err;
    logic [9:0] data_out;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int ok_cnt = 0;
    int exp_err = 0;

    crc_serial_check dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_sof(in_sof), .busy(busy), .frame_done(frame_done),
        .crc_ok(crc_ok), .crc_err(crc_err), .data_out(data_out),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt++;
            if (crc_ok) ok_cnt++;
        end
    end

    // Remainder of the 19-bit codeword divided by x^9+x^8+x+1.
    function automatic logic [8:0] ref_rem(input logic [18:0] cw);
        logic [18:0] r;
        r = cw;
        for (int i = 18; i >= 9; i--)
            if (r[i]) r = r ^ (19'h303 << (i - 9));
        return r[8:0];
    endfunction

    function automatic logic [8:0] crc_of(input logic [9:0] d);
        return ref_rem({d, 9'h000});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input logic v, input logic b, input logic s);
        @(posedge clk);
        #1;
        in_valid = v;
        in_bit   = b;
        in_sof   = s;
    endtask

    // Drives all 19 bits; the last bit is left on the inputs unconsumed.
    task automatic send_frame(input logic [9:0] d, input logic [8:0] c, input bit gaps);
        logic [18:0] cw;
        cw = {d, c};
        for (int i = 0; i < 19; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'b0);
            tick(1'b1, cw[18 - i], i == 0);
        end
    endtask

    task automatic bump_err(input logic [9:0] d, input logic [8:0] c);
        if (ref_rem({d, c}) != 9'h000 && exp_err < 255) exp_err++;
    endtask

    initial begin
        logic [9:0] d;
        logic [8:0] c;
        logic       exp_ok;
        int         d0, ok0;

        in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0;
        reset = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ok", crc_ok, 0);
        check("rst_err", crc_err, 0);
        check("rst_data", data_out, 0);
        check("rst_errcnt", err_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Stray bits without in_sof are ignored while idle.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        #1 check("idle_ignore_busy", busy, 0);

        send_frame(10'h000, 9'h000, 0);
        #1 check("mid_busy", busy, 1);
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("zero_done", frame_done, 1);
        check("zero_ok", crc_ok, 1);
        check("zero_err", crc_err, 0);
        check("zero_data", data_out, 10'h000);
        check("zero_errcnt", err_count, 0);
        check("zero_busy", busy, 0);
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("done_pulse_width", frame_done, 0);
        check("ok_held", crc_ok, 1);

        send_frame(10'h001, 9'h103, 0);
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("f001_ok", crc_ok, 1);
        check("f001_data", data_out, 10'h001);
        send_frame(10'h002, 9'h105, 0);
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("f002_ok", crc_ok, 1);
        check("f002_data", data_out, 10'h002);

        send_frame(10'h001, 9'h102, 0);
        bump_err(10'h001, 9'h102);
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("flip_err", crc_err, 1);
        check("flip_ok", crc_ok, 0);
        check("flip_errcnt", err_count, exp_err);

        for (int n = 0; n < 16; n++) begin
            d = 10'($urandom_range(0, 1023));
            c = crc_of(d);
            if ($urandom_range(0, 1) == 1) c = c ^ 9'(1 << $urandom_range(0, 8));
            exp_ok = (ref_rem({d, c}) == 9'h000);
            bump_err(d, c);
            send_frame(d, c, 1);
            tick(1'b0, 1'b0, 1'b0);
            #1;
            check("rnd_done", frame_done, 1);
            check("rnd_data", data_out, d);
            check("rnd_ok", crc_ok, exp_ok);
            check("rnd_err", crc_err, !exp_ok);
            check("rnd_errcnt", err_count, exp_err);
        end

        // Gapped frame followed by a zero-gap frame starting in the done cycle.
        tick(1'b0, 1'b0, 1'b0);
        d0 = done_cnt; ok0 = ok_cnt;
        send_frame(10'h002, 9'h105, 1);
        send_frame(10'h001, 9'h103, 0);
        tick(1'b0, 1'b0, 1'b0);
        #1 check("b2b_data", data_out, 10'h001);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("b2b_pulses", done_cnt - d0, 2);
        check("b2b_oks", ok_cnt - ok0, 2);

        // Abort at bit 7 by a fresh in_sof.
        send_frame(10'h002, 9'h105, 0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        for (int i = 0; i < 7; i++) tick(1'b1, 1'($urandom_range(0, 1)), i == 0);
        send_frame(10'h001, 9'h103, 0);
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("abort_ok", crc_ok, 1);
        check("abort_data", data_out, 10'h001);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("abort_pulses", done_cnt - d0, 1);

        // Reset pulsed mid-frame at bit 12.
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, i == 0);
        #1 reset = 1'b1;
        #1;
        exp_err = 0;
        check("mrst_busy", busy, 0);
        check("mrst_ok", crc_ok, 0);
        check("mrst_err", crc_err, 0);
        check("mrst_data", data_out, 0);
        check("mrst_errcnt", err_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        d0 = done_cnt;
        for (int i = 12; i < 19; i++) tick(1'b1, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        check("mrst_pulses", done_cnt - d0, 0);
        check("mrst_busy_after", busy, 0);

        // Error counter saturation.
        for (int n = 0; n < 300; n++) begin
            send_frame(10'h001, 9'h102, 0);
            bump_err(10'h001, 9'h102);
            if (n == 254) begin
                tick(1'b0, 1'b0, 1'b0);
                #1 check("sat_reach", err_count, exp_err);
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        #1;
        check("sat_hold", err_count, exp_err);
        check("sat_err", crc_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
